io_output_bank: RTL and testbench

Parametrised memory-mapped output port bank on the CPU I/O bus. Drives NUM_PORTS output ports of DATA_W bits each. Adds per-port pulse mode: a written value auto-clears after a programmable number of cycles. Adds an optional registered readback path. Sits beside the data memory and decodes word addresses addr[7:2] on the I/O write strobe.

---
 rtl/io_bank_pkg.sv | 31 +++
 rtl/io_pulse_chan.sv | 55 +++++
 rtl/io_output_bank.sv | 111 +++++++++++
 tb/tb_io_output_bank.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/io_bank_pkg.sv
// Shared definitions for the I/O output bank: address offsets and the word-index decoder.
package io_bank_pkg;

    localparam int unsigned IDX_W = 6;

    typedef struct packed {
        logic             hit;
        logic [IDX_W-1:0] off;
    } idx_dec_t;

    function automatic int unsigned off_pulse_mask(input int unsigned num_ports);
        return num_ports;
    endfunction

    function automatic int unsigned off_pulse_len(input int unsigned num_ports);
        return num_ports + 1;
    endfunction

    // Offset of idx relative to base; hit only when base <= idx <= base+last_off.
    function automatic idx_dec_t decode_idx(input logic [IDX_W-1:0] idx,
                                            input logic [IDX_W-1:0] base,
                                            input logic [IDX_W-1:0] last_off);
        logic [IDX_W:0] diff;
        idx_dec_t       r;
        diff  = {1'b0, idx} - {1'b0, base};
        r.off = diff[IDX_W-1:0];
        r.hit = !diff[IDX_W] && (diff[IDX_W-1:0] <= last_off);
        return r;
    endfunction

endpackage

// File: rtl/io_pulse_chan.sv
// One output port: data register plus pulse-mode down-counter with auto-clear on expiry.
module io_pulse_chan
    import io_bank_pkg::*;
#(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned PULSE_W = 8
) (
    input  logic               clk,
    input  logic               clr,
    input  logic               wr_en,
    input  logic [DATA_W-1:0]  wdata,
    input  logic               pulse_mode,
    input  logic [PULSE_W-1:0] pulse_len,
    output logic [DATA_W-1:0]  data_o,
    output logic               active_c
);

    logic [DATA_W-1:0]  data_q, data_d;
    logic [PULSE_W-1:0] cnt_q, cnt_d;
    logic [PULSE_W-1:0] load_val;

    assign load_val = (pulse_len == '0) ? PULSE_W'(1) : pulse_len;

    // Priority: write > mode-off cancel > countdown/expiry.
    always_comb begin
        data_d = data_q;
        cnt_d  = cnt_q;
        if (!pulse_mode) begin
            cnt_d = '0;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - PULSE_W'(1);
            if (cnt_q == PULSE_W'(1)) begin
                data_d = '0;
            end
        end
        if (wr_en) begin
            data_d = wdata;
            cnt_d  = pulse_mode ? load_val : '0;
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            data_q <= '0;
            cnt_q  <= '0;
        end else begin
            data_q <= data_d;
            cnt_q  <= cnt_d;
        end
    end

    assign data_o   = data_q;
    assign active_c = (cnt_q != '0);

endmodule

// File: rtl/io_output_bank.sv
// Memory-mapped output port bank with per-port pulse mode.
// Optional registered readback path enabled by defining IO_OUTPUT_READBACK_EN.
module io_output_bank
    import io_bank_pkg::*;
#(
    parameter int unsigned      NUM_PORTS = 4,
    parameter int unsigned      DATA_W    = 32,
    parameter logic [IDX_W-1:0] BASE_IDX  = 6'h20,
    parameter int unsigned      PULSE_W   = 8
) (
    input  logic                        io_clk,
    input  logic                        clr,
    input  logic [31:0]                 addr,
    input  logic [DATA_W-1:0]           datain,
    input  logic                        write_io_enable,
    input  logic                        read_io_enable,
    output logic [DATA_W-1:0]           dataout,
    output logic [NUM_PORTS*DATA_W-1:0] out_port,
    output logic [NUM_PORTS-1:0]        pulse_active
);

    localparam logic [IDX_W-1:0] OFF_PULSE_MASK = IDX_W'(off_pulse_mask(NUM_PORTS));
    localparam logic [IDX_W-1:0] OFF_PULSE_LEN  = IDX_W'(off_pulse_len(NUM_PORTS));

    idx_dec_t             dec;
    logic [NUM_PORTS-1:0] mask_q, mask_d;
    logic [PULSE_W-1:0]   len_q, len_d;
    logic                 wr_mask, wr_len;

    assign dec     = decode_idx(addr[7:2], BASE_IDX, OFF_PULSE_LEN);
    assign wr_mask = write_io_enable && dec.hit && (dec.off == OFF_PULSE_MASK);
    assign wr_len  = write_io_enable && dec.hit && (dec.off == OFF_PULSE_LEN);

    always_comb begin
        mask_d = mask_q;
        len_d  = len_q;
        if (wr_mask) mask_d = datain[NUM_PORTS-1:0];
        if (wr_len)  len_d  = datain[PULSE_W-1:0];
    end

    always_ff @(posedge io_clk) begin
        if (clr) begin
            mask_q <= '0;
            len_q  <= '0;
        end else begin
            mask_q <= mask_d;
            len_q  <= len_d;
        end
    end

    // Channels see the next-edge mask so a mask clear cancels the counter on its own edge.
    for (genvar i = 0; i < NUM_PORTS; i++) begin : g_chan
        logic wr_port;
        assign wr_port = write_io_enable && dec.hit && (dec.off == IDX_W'(i));

        io_pulse_chan #(
            .DATA_W  (DATA_W),
            .PULSE_W (PULSE_W)
        ) u_chan (
            .clk        (io_clk),
            .clr        (clr),
            .wr_en      (wr_port),
            .wdata      (datain),
            .pulse_mode (mask_d[i]),
            .pulse_len  (len_q),
            .data_o     (out_port[i*DATA_W +: DATA_W]),
            .active_c   (pulse_active[i])
        );
    end

`ifdef IO_OUTPUT_READBACK_EN
    logic [DATA_W-1:0] rd_q, rd_d, rd_data_c;

    // Readback mux uses current register values, so a same-cycle write reads the old value.
    always_comb begin
        rd_data_c = '0;
        if (dec.hit) begin
            if (dec.off == OFF_PULSE_MASK) begin
                rd_data_c = DATA_W'(mask_q);
            end else if (dec.off == OFF_PULSE_LEN) begin
                rd_data_c = DATA_W'(len_q);
            end else begin
                for (int p = 0; p < NUM_PORTS; p++) begin
                    if (dec.off == IDX_W'(p)) rd_data_c = out_port[p*DATA_W +: DATA_W];
                end
            end
        end
    end

    always_comb begin
        rd_d = rd_q;
        if (read_io_enable) rd_d = rd_data_c;
    end

    always_ff @(posedge io_clk) begin
        if (clr) rd_q <= '0;
        else     rd_q <= rd_d;
    end

    assign dataout = rd_q;

    logic unused_c;
    assign unused_c = ^{addr[31:8], addr[1:0]};
`else
    assign dataout = '0;

    logic unused_c;
    assign unused_c = ^{addr[31:8], addr[1:0], read_io_enable};
`endif

endmodule

// File: tb/tb_io_output_bank.sv
// Directed self-checking bench for io_output_bank (default parameters).
module tb_io_output_bank;

    localparam int unsigned NP = 4;
    localparam int unsigned DW = 32;

    logic              io_clk = 1'b0;
    logic              clr = 1'b0;
    logic [31:0]       addr = '0;
    logic [DW-1:0]     datain = '0;
    logic              write_io_enable = 1'b0;
    logic              read_io_enable = 1'b0;
    logic [DW-1:0]     dataout;
    logic [NP*DW-1:0]  out_port;
    logic [NP-1:0]     pulse_active;

    int n_cmp = 0;
    int n_bad = 0;

    io_output_bank dut (
        .io_clk          (io_clk),
        .clr             (clr),
        .addr            (addr),
        .datain          (datain),
        .write_io_enable (write_io_enable),
        .read_io_enable  (read_io_enable),
        .dataout         (dataout),
        .out_port        (out_port),
        .pulse_active    (pulse_active)
    );

    always #5 io_clk = ~io_clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] port(input int i);
        return out_port[i*DW +: DW];
    endfunction

    // Called at a negedge; returns at the negedge after the write edge.
    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        addr = a; datain = d; write_io_enable = 1'b1;
        @(negedge io_clk);
        write_io_enable = 1'b0;
    endtask

    task automatic rd(input logic [31:0] a);
        addr = a; read_io_enable = 1'b1;
        @(negedge io_clk);
        read_io_enable = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge io_clk);
    endtask

    initial begin
        @(negedge io_clk);
        clr = 1'b1;
        @(negedge io_clk);
        clr = 1'b0;
        check("reset_ports", out_port, '0);
        check("reset_active", pulse_active, '0);
        check("reset_dataout", dataout, '0);

        // Level write
        wr(32'h80, 32'hDEADBEEF);
        check("level_port0", port(0), 32'hDEADBEEF);
        check("level_others", out_port[NP*DW-1:DW], '0);
        check("level_active", pulse_active, '0);

        // Pulse of length 3 on port 1
        wr(32'h94, 32'd3);
        wr(32'h90, 32'h2);
        wr(32'h84, 32'h55);
        check("pulse_c1_val", port(1), 32'h55);
        check("pulse_c1_act", pulse_active, 4'b0010);
        idle(1);
        check("pulse_c2_val", port(1), 32'h55);
        idle(1);
        check("pulse_c3_val", port(1), 32'h55);
        check("pulse_c3_act", pulse_active, 4'b0010);
        idle(1);
        check("pulse_end_val", port(1), 32'h0);
        check("pulse_end_act", pulse_active, 4'b0000);
        check("pulse_port0_kept", port(0), 32'hDEADBEEF);

        // Reload on the expiry cycle
        wr(32'h94, 32'd2);
        wr(32'h84, 32'hA1);
        idle(1);
        check("reload_pre", port(1), 32'hA1);
        wr(32'h84, 32'hB2);
        check("reload_val", port(1), 32'hB2);
        check("reload_act", pulse_active, 4'b0010);
        idle(1);
        check("reload_hold", port(1), 32'hB2);
        idle(1);
        check("reload_end", port(1), 32'h0);
        check("reload_end_act", pulse_active, 4'b0000);

        // Mask clear mid-pulse
        wr(32'h94, 32'd10);
        wr(32'h84, 32'h7);
        idle(3);
        check("mclr_pre_act", pulse_active, 4'b0010);
        wr(32'h90, 32'h0);
        check("mclr_val", port(1), 32'h7);
        check("mclr_act", pulse_active, 4'b0000);
        idle(12);
        check("mclr_hold", port(1), 32'h7);

        // Setting mask starts nothing; PULSE_LEN=0 gives a 1-cycle pulse
        wr(32'h90, 32'h2);
        check("mset_noact", pulse_active, 4'b0000);
        check("mset_val", port(1), 32'h7);
        wr(32'h94, 32'd0);
        wr(32'h84, 32'h99);
        check("len0_val", port(1), 32'h99);
        check("len0_act", pulse_active, 4'b0010);
        idle(1);
        check("len0_end", port(1), 32'h0);
        check("len0_end_act", pulse_active, 4'b0000);

        // Upper datain bits ignored for PULSE_LEN and PULSE_MASK
        wr(32'h94, 32'hABCD0102);
        wr(32'h90, 32'hFFFFFFF4);
        wr(32'h88, 32'h1111);
        check("upper_act", pulse_active, 4'b0100);
        idle(1);
        check("upper_c2", port(2), 32'h1111);
        idle(1);
        check("upper_end", port(2), 32'h0);

        // Unmapped writes
        wr(32'h8C, 32'hCAFE);
        wr(32'hFC, 32'hFFFF);
        wr(32'h98, 32'h5);
        wr(32'h7C, 32'h3);
        check("unmapped_ports", out_port, 128'h0000CAFE_00000000_00000000_DEADBEEF);
        check("unmapped_act", pulse_active, 4'b0000);
        wr(32'h88, 32'h22);
        idle(1);
        check("unmapped_len_c2", port(2), 32'h22);
        idle(1);
        check("unmapped_len_end", port(2), 32'h0);

        // Readback
        wr(32'h80, 32'h1234);
`ifdef IO_OUTPUT_READBACK_EN
        rd(32'h80);
        check("rb_port0", dataout, 32'h1234);
        rd(32'h94);
        check("rb_len", dataout, 32'h2);
        rd(32'h90);
        check("rb_mask", dataout, 32'h4);
        addr = 32'h80;
        idle(2);
        check("rb_hold", dataout, 32'h4);
        rd(32'hFC);
        check("rb_unmapped", dataout, 32'h0);
        addr = 32'h80; datain = 32'h5678;
        write_io_enable = 1'b1; read_io_enable = 1'b1;
        @(negedge io_clk);
        write_io_enable = 1'b0; read_io_enable = 1'b0;
        check("rb_rw_old", dataout, 32'h1234);
        check("rb_rw_port", port(0), 32'h5678);
`else
        rd(32'h80);
        check("rb_off_dataout", dataout, 32'h0);
        rd(32'h94);
        check("rb_off_dataout2", dataout, 32'h0);
        check("rb_off_port0", port(0), 32'h1234);
`endif

        // Reset mid-pulse overrides a concurrent write
        wr(32'h88, 32'h77);
        check("clr_pre_act", pulse_active, 4'b0100);
        clr = 1'b1; addr = 32'h8C; datain = 32'hFFFF; write_io_enable = 1'b1;
        @(negedge io_clk);
        clr = 1'b0; write_io_enable = 1'b0;
        check("clr_ports", out_port, '0);
        check("clr_act", pulse_active, '0);
        check("clr_dataout", dataout, '0);
        wr(32'h88, 32'h5);
        idle(3);
        check("clr_mask_level", port(2), 32'h5);
        check("clr_mask_act", pulse_active, '0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
